// File: rtl/ser10_pkg.sv
// rtl/ser10_pkg.sv - shared types and constants for the ten-bit serial transmitter
package ser10_pkg;

    localparam int   SER10_WORD_W     = 10;
    localparam logic SER10_IDLE_LEVEL = 1'b0;
    localparam int   SER10_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser10_state_e;

endpackage

// File: rtl/ser10_tx.sv
// rtl/ser10_tx.sv - ten-bit MSB-first parallel-to-serial transmitter with underrun flag
// Optional even-parity bit per frame when SER10_PARITY_EN is defined.
module ser10_tx
    import ser10_pkg::*;
#(
    parameter int   WORD_W     = SER10_WORD_W,
    parameter logic IDLE_LEVEL = SER10_IDLE_LEVEL
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              enable,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_start,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam logic [SER10_CNT_W-1:0] LAST_BIT = SER10_CNT_W'(WORD_W - 1);

    ser10_state_e            state_q, state_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic [SER10_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                    sout_q, sout_d;
    logic                    sout_valid_q, sout_valid_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;
    // Underrun is decided on the last frame bit but reported one cycle later,
    // when sout_valid falls.
    logic                    urun_set_q, urun_set_d;
    logic                    load;
`ifdef SER10_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign load = din_valid && din_ready;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            sout_q        <= IDLE_LEVEL;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            urun_set_q    <= 1'b0;
`ifdef SER10_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            urun_set_q    <= urun_set_d;
`ifdef SER10_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        urun_set_d = 1'b0;
`ifdef SER10_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = SHIFT;
                    shift_d   = din;
                    bit_cnt_d = '0;
`ifdef SER10_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            SHIFT: begin
                shift_d = {shift_q[WORD_W-2:0], 1'b0};
`ifdef SER10_PARITY_EN
                parity_d = parity_q ^ shift_q[WORD_W-1];
`endif
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef SER10_PARITY_EN
                    state_d = PARITY;
`else
                    if (load) begin
                        shift_d = din;
                    end else begin
                        state_d    = IDLE;
                        urun_set_d = enable;
                    end
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef SER10_PARITY_EN
            PARITY: begin
                if (load) begin
                    state_d   = SHIFT;
                    shift_d   = din;
                    bit_cnt_d = '0;
                    parity_d  = 1'b0;
                end else begin
                    state_d    = IDLE;
                    urun_set_d = enable;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        din_ready     = 1'b0;
        sout_d        = IDLE_LEVEL;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        case (state_q)
            IDLE: din_ready = enable;
            SHIFT: begin
`ifndef SER10_PARITY_EN
                din_ready = enable && (bit_cnt_q == LAST_BIT);
`endif
                sout_d        = shift_q[WORD_W-1];
                sout_valid_d  = 1'b1;
                frame_start_d = (bit_cnt_q == '0);
            end
`ifdef SER10_PARITY_EN
            PARITY: begin
                din_ready    = enable;
                sout_d       = parity_q;
                sout_valid_d = 1'b1;
            end
`endif
            default: din_ready = 1'b0;
        endcase
        if (irst) begin
            din_ready = 1'b0;
        end
        underrun_d = urun_set_q | (underrun_q & ~underrun_clr);
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE);
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_ser10_tx.sv
// tb/tb_ser10_tx.sv - directed self-checking bench for ser10_tx
module tb_ser10_tx;

`ifdef SER10_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       iclk = 1'b0;
    logic       irst;
    logic [9:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       enable;
    logic       sout;
    logic       sout_valid;
    logic       frame_start;
    logic       busy;
    logic       underrun;
    logic       underrun_clr;

    int total = 0;
    int bad   = 0;

    always #5 iclk = ~iclk;

    ser10_tx dut (
        .iclk         (iclk),
        .irst         (irst),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .enable       (enable),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .frame_start  (frame_start),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [9:0] w, input int i);
        if (i < 10) return w[9-i];
        return ^w;
    endfunction

    logic [9:0] w1, wa, wb, wc, wd, we;

    initial begin
        w1 = 10'b1001011010;
        wa = 10'b1111000011;
        wb = 10'b1010101010;
        wc = 10'b0101010101;
        wd = 10'b1100110011;
        we = 10'b0011101001;

        irst = 1'b1; din = '0; din_valid = 1'b0; enable = 1'b0; underrun_clr = 1'b0;
        tick; tick;
        chk("rst_sout", sout, 1'b0);
        chk("rst_valid", sout_valid, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_urun", underrun, 1'b0);
        enable = 1'b1;
        #1 chk("rst_ready_forced", din_ready, 1'b0);

        // single word then underrun
        irst = 1'b0; din = w1; din_valid = 1'b1;
        #1 chk("sw_ready", din_ready, 1'b1);
        tick;
        din_valid = 1'b0;
        chk("sw_busy", busy, 1'b1);
        for (int i = 0; i < FL; i++) begin
            tick;
            chk("sw_sout", sout, exp_bit(w1, i));
            chk("sw_valid", sout_valid, 1'b1);
            chk("sw_fs", frame_start, (i == 0));
            chk("sw_urun_low", underrun, 1'b0);
        end
        tick;
        chk("sw_end_valid", sout_valid, 1'b0);
        chk("sw_end_sout", sout, 1'b0);
        chk("sw_urun_set", underrun, 1'b1);
        underrun_clr = 1'b1;
        tick;
        underrun_clr = 1'b0;
        chk("sw_urun_clr", underrun, 1'b0);

        // back-to-back
        din = wa; din_valid = 1'b1;
        tick;
        din = wb;
        for (int i = 0; i < 2 * FL; i++) begin
            tick;
            chk("b2b_sout", sout, (i < FL) ? exp_bit(wa, i) : exp_bit(wb, i - FL));
            chk("b2b_valid", sout_valid, 1'b1);
            chk("b2b_fs", frame_start, (i == 0) || (i == FL));
            chk("b2b_urun", underrun, 1'b0);
            if (i == 3) chk("b2b_ready_mid", din_ready, 1'b0);
            if (i == FL - 1) din_valid = 1'b0;
        end
        tick;
        chk("b2b_end_valid", sout_valid, 1'b0);
        chk("b2b_urun_set", underrun, 1'b1);
        underrun_clr = 1'b1;
        tick;
        underrun_clr = 1'b0;
        chk("b2b_urun_clr", underrun, 1'b0);

        // enable drop mid-frame; offered word must not be taken
        din = wc; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tick;
            chk("en_sout", sout, exp_bit(wc, i));
            chk("en_valid", sout_valid, 1'b1);
            if (i == 3) begin
                enable = 1'b0;
                din = wd;
                din_valid = 1'b1;
            end
        end
        tick;
        chk("en_end_valid", sout_valid, 1'b0);
        chk("en_urun", underrun, 1'b0);
        chk("en_ready", din_ready, 1'b0);
        chk("en_busy", busy, 1'b0);
        tick;
        chk("en_no_restart", sout_valid, 1'b0);
        din_valid = 1'b0;
        enable = 1'b1;

        // reset mid-frame
        din = wd; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rm_sout", sout, exp_bit(wd, i));
        end
        irst = 1'b1;
        tick;
        chk("rm_valid", sout_valid, 1'b0);
        chk("rm_sout_idle", sout, 1'b0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_ready", din_ready, 1'b0);
        irst = 1'b0;
        tick;
        chk("rm_idle_after", sout_valid, 1'b0);

        // fresh word after reset; clear coincident with new underrun
        din = we; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tick;
            chk("fr_sout", sout, exp_bit(we, i));
            chk("fr_valid", sout_valid, 1'b1);
            chk("fr_fs", frame_start, (i == 0));
            if (i == FL - 1) underrun_clr = 1'b1;
        end
        tick;
        underrun_clr = 1'b0;
        chk("clr_coincident", underrun, 1'b1);
        chk("fr_end_valid", sout_valid, 1'b0);
        underrun_clr = 1'b1;
        tick;
        underrun_clr = 1'b0;
        chk("clr_after", underrun, 1'b0);
        tick;
        chk("clr_stays", underrun, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser10_tx.md
# ser10_tx

Ten-bit parallel-to-serial transmitter. It sits directly downstream of the 10-bit pattern selector and takes the selected `mux_out` word through a valid/ready handshake. Each word is shifted out MSB-first, one bit per `iclk`, with frame-boundary and validity strobes. Back-to-back words stream with no gap bits, and a broken stream is flagged as an underrun.

## Interface
Parameters:
- `WORD_W`, default 10: data bits per frame. Only 10 is supported.
- `IDLE_LEVEL`, default 1'b0: level driven on `sout` when no bit is being sent.

Ports:
- `iclk` (in, 1): clock.
- `irst` (in, 1): reset, synchronous, active-high. Clock is `iclk`.
- `din` (in, 10): parallel word, driven by the selector output.
- `din_valid` (in, 1): `din` holds a word to send.
- `din_ready` (out, 1): the block accepts `din` this cycle. A transfer occurs when `din_valid && din_ready`.
- `enable` (in, 1): permits new frames to start.
- `sout` (out, 1): serial data, registered.
- `sout_valid` (out, 1): `sout` carries a frame bit, registered.
- `frame_start` (out, 1): high with the first (MSB) bit of each frame, registered.
- `busy` (out, 1): a frame is in progress (state ≠ IDLE).
- `underrun` (out, 1): sticky flag; streaming broke while `enable` was high.
- `underrun_clr` (in, 1): clears `underrun`.

## Operation
- State machine: IDLE, SHIFT, and PARITY (PARITY exists only when the macro is defined).
- Registers:
  - 10-bit shift register.
  - 4-bit `bit_cnt`, counting 0..9 and wrapping to 0 at a frame end.
  - Parity accumulator (only when the macro is defined).
- `din_ready` is combinational and high in these cases:
  - state is IDLE and `enable` is high;
  - state is SHIFT with `bit_cnt`==9, `enable` is high, and parity is disabled;
  - state is PARITY and `enable` is high.
- `din_ready` is forced to 0 while `irst` is high.
- On transfer, `din` loads the shift register and `bit_cnt` goes to 0. The next cycle drives `din[9]` with `frame_start`=1.
- In SHIFT, each cycle outputs the current MSB, shifts left and increments `bit_cnt`.
- At frame end (the last data bit, or the parity bit when enabled):
  - Transfer present: reload and stay in SHIFT, with zero gap cycles.
  - No transfer and `enable` high: set `underrun` and go to IDLE.
  - `enable` low: go to IDLE without flagging.
- Leaving IDLE from a fresh start is never an underrun.
- `enable` deasserted mid-frame: the current frame completes in full, and no new word is accepted.
- `din_valid` is ignored while `din_ready` is low. `din` is sampled only at transfer.
- `underrun`: a set and `underrun_clr` in the same cycle leaves the flag at 1 (set wins).

## Timing
- Reset values: `sout`=`IDLE_LEVEL`, `sout_valid`=0, `frame_start`=0, `busy`=0, `underrun`=0. State is IDLE and `bit_cnt`=0.
- Latency: transfer at edge N puts the MSB on `sout` after edge N+1. LSB follows after edge N+10. Add N+11 for the parity bit.
- Throughput: one word per 10 cycles, or 11 with parity.
- Continuous streaming: `sout_valid` stays high with no holes. `frame_start` pulses every 10 (or 11) cycles.
- Outside a frame, `sout`=`IDLE_LEVEL` and `sout_valid`=0.
- Reset mid-frame: the frame is aborted. After that edge, outputs hold reset values and the partial word is discarded.
- `underrun` asserts on the cycle after the last frame bit, coincident with `sout_valid` falling.

## Configuration
- `SER10_PARITY_EN` defined:
  - After bit 0, one extra bit is sent: even parity over the 10 data bits, so the total ones count in 11 bits is even.
  - `sout_valid` is high for the parity bit and `frame_start` is low.
  - Frames are 11 cycles and `din_ready` shifts to the PARITY cycle.
- `SER10_PARITY_EN` not defined: frames are exactly 10 bits, and no PARITY state or accumulator exists.

## Structure
- Package `ser10_pkg` holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - `SER10_WORD_W`=10;
  - `SER10_IDLE_LEVEL` default;
  - the `bit_cnt` width constant.
- No sub-module is warranted. The shift register, counter and parity logic stay inline in `ser10_tx`.

## Test plan
- **Single word:** `enable`=1, one transfer of 10'b1001011010 at edge N, then `din_valid`=0.
  - `sout` = 1,0,0,1,0,1,1,0,1,0 after edges N+1..N+10.
  - `frame_start` high only at N+1.
  - `underrun`=1 from N+11.
- **Back-to-back:** 10'b1111000011 then 10'b1010101010 held valid.
  - 20 contiguous valid bits, `frame_start` at cycle offsets 0 and 10, `underrun` stays 0 while valid is kept.
- **Enable drop:** `enable` low at bit 3 of 10'b0101010101.
  - All 10 bits still sent, then IDLE with `underrun`=0 and `din_ready`=0.
- **Reset mid-frame:** `irst` high at bit 4.
  - Next cycle `sout_valid`=0, `sout`=`IDLE_LEVEL`, `busy`=0.
  - A fresh word after reset sends its full 10 bits.
- **Underrun clear:**
  - `underrun_clr` pulse clears the flag.
  - A clr coincident with a new underrun leaves `underrun`=1.
- **Parity, with `SER10_PARITY_EN`:** send 10'b1001011010 (five ones).
  - The 11th bit is 1, and the next `frame_start` comes 11 cycles after the first.
